// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter with a valid/ready input FIFO and optional parity.
// Frames are timed in sample_tick units and go out back-to-back while data is queued.
module uart_tx_fifo_param #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clock,
   input  logic                                 reset_n,
   input  logic                                 sample_tick,
   input  logic [DATA_BITS-1:0]                 in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   output logic                                 tx,
   output logic                                 tx_done,
   output logic                                 busy,
   output logic                                 chg_state,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(STOP_BITS * OVERSAMPLE);
   localparam int NW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] BIT_LAST   = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] STOP_LAST  = SW'(STOP_BITS * OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST     = NW'(DATA_BITS - 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        level;
   logic                 full, empty, push, pop;
   logic [DATA_BITS-1:0] head;

   state_t               state, state_nxt;
   logic [SW-1:0]        s_cnt, s_cnt_nxt;
   logic [NW-1:0]        n_cnt, n_cnt_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 par_bit, par_nxt;
   logic                 tx_nxt, busy_nxt, chg_nxt, done_nxt;

   assign full       = (level == FULL_LEVEL);
   assign empty      = (level == '0);
   assign in_ready   = !full;
   assign push       = in_valid && !full;
   assign head       = mem[rd_ptr];
   assign fifo_level = level;

   // A full FIFO refuses the push even when the FSM pops in the same cycle.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            level <= level + LW'(1);
         end else if (!push && pop) begin
            level <= level - LW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         s_cnt     <= '0;
         n_cnt     <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         chg_state <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_nxt;
         s_cnt     <= s_cnt_nxt;
         n_cnt     <= n_cnt_nxt;
         shreg     <= shreg_nxt;
         par_bit   <= par_nxt;
         tx        <= tx_nxt;
         busy      <= busy_nxt;
         chg_state <= chg_nxt;
         tx_done   <= done_nxt;
      end
   end

   // Parity is latched from the FIFO head at pop time, before the shifter consumes it.
   always_comb begin
      state_nxt = state;
      s_cnt_nxt = s_cnt;
      n_cnt_nxt = n_cnt;
      shreg_nxt = shreg;
      par_nxt   = par_bit;
      pop       = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (sample_tick) begin
               if (s_cnt == BIT_LAST) begin
                  state_nxt = ST_DATA;
               end else begin
                  s_cnt_nxt = s_cnt + SW'(1);
               end
            end
         end
         ST_DATA: begin
            if (sample_tick) begin
               if (s_cnt == BIT_LAST) begin
                  s_cnt_nxt = '0;
                  shreg_nxt = shreg >> 1;
                  if (n_cnt == N_LAST) begin
                     state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     n_cnt_nxt = n_cnt + NW'(1);
                  end
               end else begin
                  s_cnt_nxt = s_cnt + SW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (sample_tick) begin
               if (s_cnt == BIT_LAST) begin
                  state_nxt = ST_STOP;
               end else begin
                  s_cnt_nxt = s_cnt + SW'(1);
               end
            end
         end
         ST_STOP: begin
            if (sample_tick) begin
               if (s_cnt == STOP_LAST) begin
                  done_nxt = 1'b1;
                  if (!empty) begin
                     pop       = 1'b1;
                     state_nxt = ST_START;
                  end else begin
                     state_nxt = ST_IDLE;
                  end
               end else begin
                  s_cnt_nxt = s_cnt + SW'(1);
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      if (pop) begin
         shreg_nxt = head;
         par_nxt   = (^head) ^ 1'(PARITY_ODD);
      end
      if (state_nxt != state) begin
         s_cnt_nxt = '0;
         n_cnt_nxt = '0;
      end
   end

   // Outputs are decoded from the next state so they register on the same edge as the state.
   always_comb begin
      tx_nxt   = 1'b1;
      busy_nxt = (state_nxt != ST_IDLE);
      chg_nxt  = (state_nxt != state);
      case (state_nxt)
         ST_START:  tx_nxt = 1'b0;
         ST_DATA:   tx_nxt = shreg_nxt[0];
         ST_PARITY: tx_nxt = par_nxt;
         default:   tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench for uart_tx_fifo_param: four parameter sets share clock, reset and tick,
// a negedge monitor rebuilds each frame from mid-bit samples counted in ticks.
module tb_uart_tx_fifo_param;

   typedef struct {
      int          inst;
      logic [15:0] bits;
      int          clocks;
      int          ticks;
      logic        tx_end;
      logic        busy_end;
   } frame_t;

   localparam int OS     = 16;
   localparam int NB [4] = '{10, 11, 11, 10};

   logic       clock;
   logic       reset_n;
   logic       sample_tick;
   logic [7:0] in_data;
   logic [3:0] valid;
   logic [3:0] rdy_w, tx_w, done_w, busy_w, chg_w;
   logic [2:0] lvl_w [4];

   int     checks = 0;
   int     errors = 0;
   bit     tick_random = 1'b0;
   int     tick_cnt;
   frame_t frame_q[$];
   bit     in_frame [4] = '{default: 1'b0};
   int     consumed [4] = '{default: 0};
   int     clocks [4]   = '{default: 0};
   int     kbit [4]     = '{default: 0};
   logic [15:0] fbits [4];
   int     done_cnt [4] = '{default: 0};
   int     d0, d1, d2, d3;

   uart_tx_fifo_param u_def (
      .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
      .in_data(in_data), .in_valid(valid[0]), .in_ready(rdy_w[0]),
      .tx(tx_w[0]), .tx_done(done_w[0]), .busy(busy_w[0]),
      .chg_state(chg_w[0]), .fifo_level(lvl_w[0])
   );

   uart_tx_fifo_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_par_even (
      .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
      .in_data(in_data), .in_valid(valid[1]), .in_ready(rdy_w[1]),
      .tx(tx_w[1]), .tx_done(done_w[1]), .busy(busy_w[1]),
      .chg_state(chg_w[1]), .fifo_level(lvl_w[1])
   );

   uart_tx_fifo_param #(.PARITY_EN(1), .PARITY_ODD(1)) u_par_odd (
      .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
      .in_data(in_data), .in_valid(valid[2]), .in_ready(rdy_w[2]),
      .tx(tx_w[2]), .tx_done(done_w[2]), .busy(busy_w[2]),
      .chg_state(chg_w[2]), .fifo_level(lvl_w[2])
   );

   uart_tx_fifo_param #(.DATA_BITS(7), .STOP_BITS(2)) u_d7s2 (
      .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
      .in_data(in_data[6:0]), .in_valid(valid[3]), .in_ready(rdy_w[3]),
      .tx(tx_w[3]), .tx_done(done_w[3]), .busy(busy_w[3]),
      .chg_state(chg_w[3]), .fifo_level(lvl_w[3])
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Tick strobe: every 4 clocks, or a random 1-9 clock spacing when tick_random is set.
   initial begin
      sample_tick = 1'b0;
      tick_cnt    = 0;
      forever begin
         @(posedge clock);
         #1;
         if (tick_cnt == 0) begin
            sample_tick = 1'b1;
            tick_cnt    = tick_random ? int'($urandom_range(9, 1)) - 1 : 3;
         end else begin
            sample_tick = 1'b0;
            tick_cnt--;
         end
      end
   end

   // Frame monitor: bit k is sampled once k*OS+OS/2 ticks have elapsed since the start bit.
   always @(negedge clock) begin
      for (int i = 0; i < 4; i++) begin
         if (done_w[i] === 1'b1) done_cnt[i]++;
         if (reset_n !== 1'b1) begin
            in_frame[i] = 1'b0;
         end else begin
            if (in_frame[i] && clocks[i] > 0 && done_w[i] === 1'b1) begin
               frame_q.push_back('{i, fbits[i], clocks[i], consumed[i], tx_w[i], busy_w[i]});
               in_frame[i] = 1'b0;
            end
            if (!in_frame[i] && tx_w[i] === 1'b0) begin
               in_frame[i] = 1'b1;
               consumed[i] = 0;
               clocks[i]   = 0;
               kbit[i]     = 0;
               fbits[i]    = '0;
            end
            if (in_frame[i]) begin
               if (kbit[i] < NB[i] && consumed[i] == kbit[i] * OS + OS / 2) begin
                  fbits[i][kbit[i]] = tx_w[i];
                  kbit[i]++;
               end
               if (sample_tick === 1'b1) consumed[i]++;
               clocks[i]++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] mask, input logic [7:0] data);
      in_data = data;
      valid   = mask;
      step();
      valid   = 4'b0000;
   endtask

   // Leaves the bench so that the next push makes the start edge coincide with a tick edge.
   task automatic align_tick();
      int n = 0;
      step();
      while (sample_tick !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check_output("tick_align", 32'(sample_tick), 32'd1);
      repeat (3) step();
   endtask

   task automatic check_frame(input string tag, input int inst, input logic [15:0] exp_bits,
                              input int exp_ticks, input int exp_clocks,
                              input logic exp_tx_end, input logic exp_busy_end);
      frame_t f;
      int     n = 0;
      while (frame_q.size() == 0 && n < 4000) begin
         @(negedge clock);
         n++;
      end
      check_output({tag, "_arrived"}, 32'(frame_q.size() != 0), 32'd1);
      if (frame_q.size() != 0) begin
         f = frame_q.pop_front();
         check_output({tag, "_inst"}, 32'(f.inst), 32'(inst));
         check_output({tag, "_bits"}, 32'(f.bits), 32'(exp_bits));
         check_output({tag, "_ticks"}, 32'(f.ticks), 32'(exp_ticks));
         if (exp_clocks >= 0) check_output({tag, "_clocks"}, 32'(f.clocks), 32'(exp_clocks));
         check_output({tag, "_tx_end"}, 32'(f.tx_end), 32'(exp_tx_end));
         check_output({tag, "_busy_end"}, 32'(f.busy_end), 32'(exp_busy_end));
      end
   endtask

   initial begin
      reset_n = 1'b0;
      valid   = 4'b0000;
      in_data = 8'h00;
      repeat (3) step();
      check_output("rst_tx", 32'(tx_w), 32'hF);
      check_output("rst_busy", 32'(busy_w), 32'h0);
      check_output("rst_chg", 32'(chg_w), 32'h0);
      check_output("rst_done", 32'(done_w), 32'h0);
      check_output("rst_ready", 32'(rdy_w), 32'hF);
      check_output("rst_level0", 32'(lvl_w[0]), 32'd0);
      check_output("rst_level3", 32'(lvl_w[3]), 32'd0);
      reset_n = 1'b1;
      step();

      // 8N1 frame of 0x55 with one-clock push-to-start latency
      d0 = done_cnt[0];
      align_tick();
      apply_stimulus(4'b0001, 8'h55);
      check_output("t1_level_push", 32'(lvl_w[0]), 32'd1);
      check_output("t1_tx_idle", 32'(tx_w[0]), 32'd1);
      step();
      check_output("t1_tx_start", 32'(tx_w[0]), 32'd0);
      check_output("t1_busy", 32'(busy_w[0]), 32'd1);
      check_output("t1_chg_pulse", 32'(chg_w[0]), 32'd1);
      check_output("t1_level_pop", 32'(lvl_w[0]), 32'd0);
      step();
      check_output("t1_chg_clear", 32'(chg_w[0]), 32'd0);
      check_frame("t1", 0, 16'h02AA, 160, 640, 1'b1, 1'b0);
      step();
      check_output("t1_busy_after", 32'(busy_w[0]), 32'd0);
      check_output("t1_done_count", 32'(done_cnt[0] - d0), 32'd1);

      // parity: even and odd on 0x07, 11 bit periods
      align_tick();
      apply_stimulus(4'b0010, 8'h07);
      check_frame("t2_even", 1, 16'h060E, 176, 704, 1'b1, 1'b0);
      align_tick();
      apply_stimulus(4'b0100, 8'h07);
      check_frame("t2_odd", 2, 16'h040E, 176, 704, 1'b1, 1'b0);

      // six consecutive pushes into a depth-4 FIFO, five frames back-to-back
      d0 = done_cnt[0];
      align_tick();
      in_data = 8'h11;
      valid   = 4'b0001;
      step();
      in_data = 8'h22;
      step();
      check_output("t3_level_pushpop", 32'(lvl_w[0]), 32'd1);
      in_data = 8'h33;
      step();
      in_data = 8'h44;
      step();
      in_data = 8'h55;
      step();
      check_output("t3_level_full", 32'(lvl_w[0]), 32'd4);
      check_output("t3_ready_full", 32'(rdy_w[0]), 32'd0);
      in_data = 8'h66;
      step();
      check_output("t3_level_reject", 32'(lvl_w[0]), 32'd4);
      check_output("t3_ready_reject", 32'(rdy_w[0]), 32'd0);
      valid = 4'b0000;
      check_frame("t3_f1", 0, 16'h0222, 160, 640, 1'b0, 1'b1);
      check_frame("t3_f2", 0, 16'h0244, 160, 640, 1'b0, 1'b1);
      check_frame("t3_f3", 0, 16'h0266, 160, 640, 1'b0, 1'b1);
      check_frame("t3_f4", 0, 16'h0288, 160, 640, 1'b0, 1'b1);
      check_frame("t3_f5", 0, 16'h02AA, 160, 640, 1'b1, 1'b0);
      repeat (100) step();
      check_output("t3_done_count", 32'(done_cnt[0] - d0), 32'd5);
      check_output("t3_no_extra", 32'(frame_q.size()), 32'd0);
      check_output("t3_busy_after", 32'(busy_w[0]), 32'd0);

      // 7 data bits, 2 stop bits
      d3 = done_cnt[3];
      align_tick();
      apply_stimulus(4'b1000, 8'h7F);
      check_frame("t4", 3, 16'h03FE, 160, 640, 1'b1, 1'b0);
      step();
      check_output("t4_level", 32'(lvl_w[3]), 32'd0);
      check_output("t4_done_count", 32'(done_cnt[3] - d3), 32'd1);

      // reset during data bit 3 with two bytes queued
      align_tick();
      in_data = 8'hF7;
      valid   = 4'b0001;
      step();
      in_data = 8'h18;
      step();
      in_data = 8'h29;
      step();
      valid = 4'b0000;
      check_output("t5_level_queued", 32'(lvl_w[0]), 32'd2);
      repeat (280) step();
      check_output("t5_tx_bit3", 32'(tx_w[0]), 32'd0);
      check_output("t5_busy_pre", 32'(busy_w[0]), 32'd1);
      d0 = done_cnt[0];
      reset_n = 1'b0;
      #1;
      check_output("t5_tx_reset", 32'(tx_w[0]), 32'd1);
      check_output("t5_busy_reset", 32'(busy_w[0]), 32'd0);
      check_output("t5_level_reset", 32'(lvl_w[0]), 32'd0);
      check_output("t5_ready_reset", 32'(rdy_w[0]), 32'd1);
      repeat (3) step();
      reset_n = 1'b1;
      repeat (5) step();
      check_output("t5_no_done", 32'(done_cnt[0] - d0), 32'd0);
      check_output("t5_no_frame", 32'(frame_q.size()), 32'd0);
      check_output("t5_tx_idle", 32'(tx_w[0]), 32'd1);
      align_tick();
      apply_stimulus(4'b0001, 8'h3C);
      check_frame("t5_after", 0, 16'h0278, 160, 640, 1'b1, 1'b0);

      // irregular tick spacing: boundaries follow ticks, not clocks
      tick_random = 1'b1;
      d1 = done_cnt[1];
      d2 = done_cnt[2];
      step();
      apply_stimulus(4'b0001, 8'hC3);
      check_frame("t6_def", 0, 16'h0386, 160, -1, 1'b1, 1'b0);
      step();
      apply_stimulus(4'b0010, 8'hA5);
      check_frame("t6_par", 1, 16'h054A, 176, -1, 1'b1, 1'b0);
      tick_random = 1'b0;
      step();
      check_output("t6_done_count", 32'(done_cnt[1] - d1), 32'd1);
      check_output("t6_odd_idle", 32'(done_cnt[2] - d2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
